// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_arb_pkg;
  localparam int NUM_MASTERS = 2;
  localparam int ADR_W       = 32;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] owner_onehot(input arb_state_t st);
    case (st)
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone B4 bundle; master drives the request, slave answers with stall/ack/err.
interface if_wb;
  logic                          cyc;
  logic                          stb;
  logic [wb_arb_pkg::ADR_W-1:0]  adr;
  logic [wb_arb_pkg::DATA_W-1:0] dat_o;
  logic                          we;
  logic [wb_arb_pkg::SEL_W-1:0]  sel;
  logic                          stall;
  logic                          ack;
  logic                          err;
  logic [wb_arb_pkg::DATA_W-1:0] dat_i;

  modport master (output cyc, stb, adr, dat_o, we, sel,
                  input  stall, ack, err, dat_i);
  modport slave  (input  cyc, stb, adr, dat_o, we, sel,
                  output stall, ack, err, dat_i);
endinterface

// File: rtl/wb_outstanding_cnt.sv
// Counts accepted-but-unanswered requests; never exceeds the limit, never underflows.
module wb_outstanding_cnt #(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);
  logic dec_eff;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(MAX_OUTSTANDING));
  // A response with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign dec_eff = dec & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec_eff && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec_eff && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin two-master arbiter for pipelined Wishbone; ownership held until the owner drains.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic       clk,
  input  logic       rst,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] owner
);
  arb_state_t       state, state_nxt;
  logic             last;
  logic             req0, req1;
  logic             inc, dec, full, empty, drained;
  logic [CNT_W-1:0] cnt;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;
  assign inc  = s.stb & ~s.stall;
  assign dec  = s.ack | s.err;
  // True when the counter will be zero after this cycle's update.
  assign drained = empty | ((cnt == CNT_W'(1)) & dec & ~inc);

  wb_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == OWN0) last <= 1'b0;
      if (state == IDLE && state_nxt == OWN1) last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0:    if (!m0.stb && drained) state_nxt = IDLE;
      OWN1:    if (!m1.stb && drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.adr    = '0;
    s.dat_o  = '0;
    s.we     = 1'b0;
    s.sel    = '0;
    m0.stall = 1'b1;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_i = '0;
    m1.stall = 1'b1;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_i = '0;
    case (state)
      OWN0: begin
        // cyc stays up while responses are pending even if the master drops its own cyc.
        s.cyc    = m0.cyc | ~empty;
        s.stb    = m0.stb & ~full;
        s.adr    = m0.adr;
        s.dat_o  = m0.dat_o;
        s.we     = m0.we;
        s.sel    = m0.sel;
        m0.stall = s.stall | full;
        m0.ack   = s.ack;
        m0.err   = s.err;
        m0.dat_i = s.dat_i;
      end
      OWN1: begin
        s.cyc    = m1.cyc | ~empty;
        s.stb    = m1.stb & ~full;
        s.adr    = m1.adr;
        s.dat_o  = m1.dat_o;
        s.we     = m1.we;
        s.sel    = m1.sel;
        m1.stall = s.stall | full;
        m1.ack   = s.ack;
        m1.err   = s.err;
        m1.dat_i = s.dat_i;
      end
      default: ;
    endcase
  end

  assign owner = owner_onehot(state);
endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed vector table, corner-case sequences, randomized model comparison.
module tb_wb_arbiter2;
  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] owner;
  int         checks = 0;
  int         errors = 0;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb s_if ();

  wb_arbiter2 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .owner (owner)
  );

  always #5 clk = ~clk;

  // in = {rst, m0.cyc, m0.stb, m1.cyc, m1.stb, s.stall, s.ack, s.err}
  // ex = {owner[1:0], s.stb, s.cyc, m0.stall, m1.stall, m0.ack, m1.ack, m0.err, m1.err}
  typedef struct packed {
    logic [7:0] in;
    logic [9:0] ex;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] in, input logic [9:0] ex);
    vec_t v;
    v.in = in;
    v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one vector, checks outputs at the falling edge, then moves to just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    logic [7:0] i;
    logic [9:0] e;
    i = v.in;
    e = v.ex;
    rst = i[7];
    m0_if.cyc = i[6];  m0_if.stb = i[5];
    m1_if.cyc = i[4];  m1_if.stb = i[3];
    s_if.stall = i[2]; s_if.ack = i[1]; s_if.err = i[0];
    @(negedge clk);
    chk({tag, ".owner"},    {30'd0, owner},    {30'd0, e[9:8]});
    chk({tag, ".s_stb"},    {31'd0, s_if.stb},  {31'd0, e[7]});
    chk({tag, ".s_cyc"},    {31'd0, s_if.cyc},  {31'd0, e[6]});
    chk({tag, ".m0_stall"}, {31'd0, m0_if.stall}, {31'd0, e[5]});
    chk({tag, ".m1_stall"}, {31'd0, m1_if.stall}, {31'd0, e[4]});
    chk({tag, ".m0_ack"},   {31'd0, m0_if.ack}, {31'd0, e[3]});
    chk({tag, ".m1_ack"},   {31'd0, m1_if.ack}, {31'd0, e[2]});
    chk({tag, ".m0_err"},   {31'd0, m0_if.err}, {31'd0, e[1]});
    chk({tag, ".m1_err"},   {31'd0, m1_if.err}, {31'd0, e[0]});
    if (e[9:8] == 2'b01) begin
      chk({tag, ".s_adr"},  s_if.adr,    32'h0000_0200);
      chk({tag, ".m0_dat"}, m0_if.dat_i, 32'hDEAD_BEEF);
      chk({tag, ".m1_dat"}, m1_if.dat_i, 32'h0);
    end else if (e[9:8] == 2'b10) begin
      chk({tag, ".s_adr"},  s_if.adr,    32'h0000_0100);
      chk({tag, ".m1_dat"}, m1_if.dat_i, 32'hDEAD_BEEF);
      chk({tag, ".m0_dat"}, m0_if.dat_i, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index (-1 when nobody), outstanding count, last granted index.
  int mown = -1;
  int mcnt = 0;
  int mlast = 0;

  task automatic rand_cycle(input bit force_rst);
    logic        r, stl, ak, er;
    logic [31:0] sd;
    logic [1:0]  c, sb, wv;
    logic [31:0] ad[2];
    logic [31:0] dt[2];
    logic [3:0]  sl[2];
    logic        e_scyc, e_sstb, full, acc, resp;
    logic [1:0]  e_stall, e_ack, e_err, e_own;
    logic [31:0] e_dat[2];
    int          m, k;
    r = force_rst || ($urandom_range(99) == 0);
    for (int i = 0; i < 2; i++) begin
      sb[i] = ($urandom_range(9) < 6);
      c[i]  = sb[i] | 1'($urandom_range(1));
      ad[i] = $urandom;
      dt[i] = $urandom;
      sl[i] = 4'($urandom_range(15));
      wv[i] = 1'($urandom_range(1));
    end
    stl = ($urandom_range(3) == 0);
    k   = $urandom_range(9);
    ak  = (k < 3);
    er  = (k == 3);
    sd  = $urandom;
    rst = r;
    m0_if.cyc = c[0]; m0_if.stb = sb[0]; m0_if.adr = ad[0]; m0_if.dat_o = dt[0];
    m0_if.we = wv[0]; m0_if.sel = sl[0];
    m1_if.cyc = c[1]; m1_if.stb = sb[1]; m1_if.adr = ad[1]; m1_if.dat_o = dt[1];
    m1_if.we = wv[1]; m1_if.sel = sl[1];
    s_if.stall = stl; s_if.ack = ak; s_if.err = er; s_if.dat_i = sd;
    @(negedge clk);
    if (r) begin
      mown = -1; mcnt = 0; mlast = 0;
    end
    e_scyc = 1'b0; e_sstb = 1'b0; e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00;
    e_own = 2'b00; e_dat[0] = 32'h0; e_dat[1] = 32'h0; full = 1'b0; m = 0;
    if (mown >= 0) begin
      m = mown;
      full = (mcnt == MAXO);
      e_sstb = sb[m] & ~full;
      e_scyc = c[m] | (mcnt != 0);
      e_stall[m] = stl | full;
      e_ack[m] = ak;
      e_err[m] = er;
      e_dat[m] = sd;
      e_own = (m == 0) ? 2'b01 : 2'b10;
    end
    chk("rnd.owner",    {30'd0, owner},       {30'd0, e_own});
    chk("rnd.s_cyc",    {31'd0, s_if.cyc},    {31'd0, e_scyc});
    chk("rnd.s_stb",    {31'd0, s_if.stb},    {31'd0, e_sstb});
    chk("rnd.m0_stall", {31'd0, m0_if.stall}, {31'd0, e_stall[0]});
    chk("rnd.m1_stall", {31'd0, m1_if.stall}, {31'd0, e_stall[1]});
    chk("rnd.m0_ack",   {31'd0, m0_if.ack},   {31'd0, e_ack[0]});
    chk("rnd.m1_ack",   {31'd0, m1_if.ack},   {31'd0, e_ack[1]});
    chk("rnd.m0_err",   {31'd0, m0_if.err},   {31'd0, e_err[0]});
    chk("rnd.m1_err",   {31'd0, m1_if.err},   {31'd0, e_err[1]});
    if (mown >= 0) begin
      chk("rnd.s_adr", s_if.adr,   ad[m]);
      chk("rnd.s_dat", s_if.dat_o, dt[m]);
      chk("rnd.s_we",  {31'd0, s_if.we},  {31'd0, wv[m]});
      chk("rnd.s_sel", {28'd0, s_if.sel}, {28'd0, sl[m]});
      chk("rnd.m0_dat", m0_if.dat_i, e_dat[0]);
      chk("rnd.m1_dat", m1_if.dat_i, e_dat[1]);
    end
    if (!r) begin
      if (mown < 0) begin
        if (c[0] && sb[0] && c[1] && sb[1]) mown = 1 - mlast;
        else if (c[0] && sb[0])             mown = 0;
        else if (c[1] && sb[1])             mown = 1;
        if (mown >= 0) mlast = mown;
      end else begin
        acc  = e_sstb & ~stl;
        resp = (ak | er) && (mcnt > 0);
        mcnt = mcnt + int'(acc) - int'(resp);
        if (!sb[m] && mcnt == 0) mown = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.adr = 32'h200; m0_if.dat_o = 32'h0; m0_if.we = 0; m0_if.sel = 4'hF;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.adr = 32'h100; m1_if.dat_o = 32'h0; m1_if.we = 0; m1_if.sel = 4'hF;
    s_if.stall = 0; s_if.ack = 0; s_if.err = 0; s_if.dat_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // reset, single m1 read, idle cyc without stb, outstanding limit, ties, err response
    tbl.push_back(mk(8'b1_00_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_00_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_00_11_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_00_11_000, 10'b10_11_10_0000));
    tbl.push_back(mk(8'b0_00_10_000, 10'b10_01_10_0000));
    tbl.push_back(mk(8'b0_00_10_010, 10'b10_01_10_0100));
    tbl.push_back(mk(8'b0_00_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_10_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_10_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_11_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_11_00_000, 10'b01_11_01_0000));
    tbl.push_back(mk(8'b0_11_00_000, 10'b01_11_01_0000));
    tbl.push_back(mk(8'b0_11_00_000, 10'b01_01_11_0000));
    tbl.push_back(mk(8'b0_11_00_010, 10'b01_01_11_1000));
    tbl.push_back(mk(8'b0_11_00_000, 10'b01_11_01_0000));
    tbl.push_back(mk(8'b0_10_00_010, 10'b01_01_11_1000));
    tbl.push_back(mk(8'b0_10_00_010, 10'b01_01_01_1000));
    tbl.push_back(mk(8'b0_00_00_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_11_11_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_11_11_100, 10'b10_11_11_0000));
    tbl.push_back(mk(8'b0_11_10_000, 10'b10_01_10_0000));
    tbl.push_back(mk(8'b0_11_11_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_10_11_000, 10'b01_01_01_0000));
    tbl.push_back(mk(8'b0_00_11_000, 10'b00_00_11_0000));
    tbl.push_back(mk(8'b0_00_11_000, 10'b10_11_10_0000));
    tbl.push_back(mk(8'b0_00_10_001, 10'b10_01_10_0001));
    tbl.push_back(mk(8'b0_00_00_000, 10'b00_00_11_0000));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // reset with two requests in flight, then a stale ack
    step(mk(8'b0_11_00_000, 10'b00_00_11_0000), "rst.a");
    step(mk(8'b0_11_00_000, 10'b01_11_01_0000), "rst.b");
    step(mk(8'b0_11_00_000, 10'b01_11_01_0000), "rst.c");
    step(mk(8'b1_11_00_000, 10'b00_00_11_0000), "rst.d");
    step(mk(8'b0_00_00_010, 10'b00_00_11_0000), "rst.e");
    step(mk(8'b0_11_00_000, 10'b00_00_11_0000), "rst.f");
    step(mk(8'b0_11_00_000, 10'b01_11_01_0000), "rst.g");
    step(mk(8'b0_11_00_000, 10'b01_11_01_0000), "rst.h");
    step(mk(8'b0_11_00_000, 10'b01_01_11_0000), "rst.i");
    step(mk(8'b0_10_00_010, 10'b01_01_11_1000), "rst.j");
    step(mk(8'b0_10_00_010, 10'b01_01_01_1000), "rst.k");
    step(mk(8'b0_00_00_000, 10'b00_00_11_0000), "rst.l");

    // m1 holds the bus until drained while m0 waits; then err coinciding with a new accept
    step(mk(8'b0_11_11_000, 10'b00_00_11_0000), "drn.a");
    step(mk(8'b0_11_11_000, 10'b10_11_10_0000), "drn.b");
    step(mk(8'b0_11_11_000, 10'b10_11_10_0000), "drn.c");
    step(mk(8'b0_11_10_000, 10'b10_01_11_0000), "drn.d");
    step(mk(8'b0_11_10_010, 10'b10_01_11_0100), "drn.e");
    step(mk(8'b0_11_10_000, 10'b10_01_10_0000), "drn.f");
    step(mk(8'b0_11_10_010, 10'b10_01_10_0100), "drn.g");
    step(mk(8'b0_11_00_000, 10'b00_00_11_0000), "drn.h");
    step(mk(8'b0_11_00_000, 10'b01_11_01_0000), "drn.i");
    step(mk(8'b0_11_00_001, 10'b01_11_01_0010), "err.a");
    step(mk(8'b0_10_00_010, 10'b01_01_01_1000), "err.b");
    step(mk(8'b0_00_00_000, 10'b00_00_11_0000), "err.c");

    // eight consecutive ties must alternate, starting with m1
    w = 1;
    for (int i = 0; i < 8; i++) begin
      step(mk(8'b0_11_11_000, 10'b00_00_11_0000), $sformatf("tie%0d.idle", i));
      if (w == 1) step(mk(8'b0_11_10_000, 10'b10_01_10_0000), $sformatf("tie%0d.own", i));
      else        step(mk(8'b0_10_11_000, 10'b01_01_01_0000), $sformatf("tie%0d.own", i));
      w = 1 - w;
    end

    rand_cycle(1'b1);
    for (int n = 0; n < 3000; n++) rand_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
